pwm_multi_dt: RTL and testbench

Multi-channel, parametrised PWM generator with complementary high/low-side outputs and programmable dead time, for driving the BLDC inverter half-bridges.
- One shared period counter serves all channels.
- Each channel has its own duty register, double-buffered so that a new duty takes effect only at a period boundary.
- Sits between the commutation/speed-control logic, which writes duties, and the gate-driver pins.

---
 rtl/pwm_multi_dt.sv | 109 ++++++++++
 tb/tb_pwm_multi_dt.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_dt.sv
// Multi-channel PWM generator with one shared period counter, double-buffered duties
// and complementary high/low-side outputs separated by a programmable dead time.
module pwm_multi_dt #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int CH_W     = 2,
  parameter int DT_WIDTH = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                E,
  input  logic [WIDTH-1:0]    PERIOD,
  input  logic                WR,
  input  logic [CH_W-1:0]     WR_CH,
  input  logic [WIDTH-1:0]    WR_DATA,
  input  logic [DT_WIDTH-1:0] DEAD,
  output logic [CHANNELS-1:0] HI,
  output logic [CHANNELS-1:0] LO,
  output logic                SYNC,
  output logic [CHANNELS-1:0] FULL
);

  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    pending [CHANNELS];
  logic [WIDTH-1:0]    active  [CHANNELS];
  logic [DT_WIDTH-1:0] dcnt    [CHANNELS];
  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] cur;
  logic                eprev;
  logic                wrap;
  logic                upd;

  assign wrap = (cnt >= PERIOD);
  assign upd  = !E || wrap;

  always_comb begin
    raw = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      raw[ch] = E && (cnt < active[ch]);
    end
  end

  // Active duties read the old pending value, so a write in the wrap cycle waits a period.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt   <= '0;
      eprev <= 1'b0;
      SYNC  <= 1'b0;
      FULL  <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        pending[ch] <= '0;
        active[ch]  <= '0;
      end
    end else begin
      cnt   <= (E && !wrap) ? cnt + 1'b1 : '0;
      eprev <= E;
      SYNC  <= E && (wrap || !eprev);
      for (int ch = 0; ch < CHANNELS; ch++) begin
        FULL[ch] <= E && (active[ch] > PERIOD);
        if (upd) begin
          active[ch] <= pending[ch];
        end
        if (WR && (WR_CH == CH_W'(ch))) begin
          pending[ch] <= WR_DATA;
        end
      end
    end
  end

  // Reset preloads the gap counter so the first drive after reset also waits out DEAD.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      HI  <= '0;
      LO  <= '0;
      cur <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        dcnt[ch] <= DEAD;
      end
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (!E) begin
          HI[ch]   <= 1'b0;
          LO[ch]   <= 1'b0;
          cur[ch]  <= 1'b0;
          dcnt[ch] <= DEAD;
        end else if (raw[ch] != cur[ch]) begin
          cur[ch]  <= raw[ch];
          dcnt[ch] <= DEAD;
          if (DEAD == '0) begin
            HI[ch] <= raw[ch];
            LO[ch] <= !raw[ch];
          end else begin
            HI[ch] <= 1'b0;
            LO[ch] <= 1'b0;
          end
        end else if (dcnt[ch] > DT_WIDTH'(1)) begin
          dcnt[ch] <= dcnt[ch] - 1'b1;
          HI[ch]   <= 1'b0;
          LO[ch]   <= 1'b0;
        end else begin
          dcnt[ch] <= '0;
          HI[ch]   <= cur[ch];
          LO[ch]   <= !cur[ch];
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_dt.sv
// Bench for pwm_multi_dt: directed period/duty/dead-time scenarios plus random stress,
// all outputs checked every cycle against a history-based reference model.
module tb_pwm_multi_dt;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 3;
  localparam int CH_W     = 2;
  localparam int DT_WIDTH = 4;
  localparam int VW       = 3 * CHANNELS + 1;

  logic                CLK = 1'b0;
  logic                rstN;
  logic                e;
  logic [WIDTH-1:0]    period;
  logic                wr;
  logic [CH_W-1:0]     wrCh;
  logic [WIDTH-1:0]    wrData;
  logic [DT_WIDTH-1:0] dead;
  logic [CHANNELS-1:0] hi;
  logic [CHANNELS-1:0] lo;
  logic                sync;
  logic [CHANNELS-1:0] full;

  always #5 CLK = ~CLK;

  pwm_multi_dt #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W), .DT_WIDTH(DT_WIDTH)
  ) dut (
    .CLK(CLK), .RST_N(rstN), .E(e), .PERIOD(period), .WR(wr), .WR_CH(wrCh),
    .WR_DATA(wrData), .DEAD(dead), .HI(hi), .LO(lo), .SYNC(sync), .FULL(full)
  );

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] sbq[$];
  int expHiTotal = 0;
  int actHiTotal = 0;

  // Reference model: counter and duties by arithmetic, dead time from the age of the last raw change.
  int mcnt = 0;
  int mpend[CHANNELS];
  int mact[CHANNELS];
  bit rawPrev[CHANNELS];
  int evtCycle[CHANNELS];
  int evtDead[CHANNELS];
  bit mePrev = 0;
  int cyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic stepModel();
    logic [CHANNELS-1:0] eh, el, ef;
    bit es, wrapM;
    eh = '0; el = '0; ef = '0; es = 0;
    if (!rstN) begin
      mcnt = 0;
      mePrev = 0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        mpend[ch] = 0; mact[ch] = 0; rawPrev[ch] = 0;
        evtCycle[ch] = cyc; evtDead[ch] = int'(dead);
      end
    end else begin
      wrapM = (mcnt >= int'(period));
      es = e && (wrapM || !mePrev);
      for (int ch = 0; ch < CHANNELS; ch++) begin
        bit r;
        r = e && (mcnt < mact[ch]);
        if (!e || r != rawPrev[ch]) begin
          evtCycle[ch] = cyc;
          evtDead[ch]  = int'(dead);
        end
        if (e && (cyc + 1 >= evtCycle[ch] + evtDead[ch] + 1)) begin
          eh[ch] = r;
          el[ch] = !r;
        end
        ef[ch] = e && (mact[ch] > int'(period));
        rawPrev[ch] = r;
      end
      if (!e || wrapM) begin
        for (int ch = 0; ch < CHANNELS; ch++) mact[ch] = mpend[ch];
      end
      mcnt = (e && !wrapM) ? mcnt + 1 : 0;
      if (wr && int'(wrCh) < CHANNELS) mpend[int'(wrCh)] = int'(wrData);
      mePrev = e;
    end
    sbq.push_back({eh, el, es, ef});
    expHiTotal += $countones(eh);
    cyc++;
  endtask

  task automatic applyStimulus();
    @(posedge CLK);
    #1;
    stepModel();
    wr = 1'b0;
  endtask

  task automatic writeDuty(input int ch, input int val);
    wr = 1'b1; wrCh = CH_W'(ch); wrData = WIDTH'(val);
    applyStimulus();
  endtask

  task automatic measure(input int n, input int ch, output int hiC, output int loC,
                         output int bothLow, output int syncC);
    hiC = 0; loC = 0; bothLow = 0; syncC = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus();
      hiC += int'(hi[ch]);
      loC += int'(lo[ch]);
      bothLow += int'(!hi[ch] && !lo[ch]);
      syncC += int'(sync);
    end
  endtask

  task automatic waitCnt(input int target);
    int k;
    k = 0;
    while (mcnt != target && k < 300) begin
      applyStimulus();
      k++;
    end
    if (mcnt != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_cnt: counter %0d, required %0d", mcnt, target);
    end
  endtask

  always @(negedge CLK) begin
    if (sbq.size() > 0) begin
      logic [VW-1:0] exp;
      exp = sbq.pop_front();
      checkOutput("outputs", 32'({hi, lo, sync, full}), 32'(exp));
      checkOutput("hi_and_lo", 32'(hi & lo), 32'd0);
      actHiTotal += $countones(hi);
    end
  end

  initial begin
    int hc, lc, bl, sc, first;
    rstN = 1'b0; e = 1'b0; wr = 1'b0; wrCh = '0; wrData = '0; period = 8'd9; dead = '0;
    repeat (3) applyStimulus();
    checkOutput("reset_state", 32'({hi, lo, sync, full}), 32'd0);

    // Basic duty on channel 0
    rstN = 1'b1; e = 1'b1;
    writeDuty(0, 4);
    repeat (25) applyStimulus();
    measure(10, 0, hc, lc, bl, sc);
    checkOutput("basic_hi", hc, 4);
    checkOutput("basic_lo", lc, 6);
    checkOutput("basic_sync", sc, 1);

    // Dead time on channel 1
    period = 8'd19; dead = 4'd3;
    writeDuty(1, 10);
    repeat (45) applyStimulus();
    measure(20, 1, hc, lc, bl, sc);
    checkOutput("dead_hi", hc, 7);
    checkOutput("dead_lo", lc, 7);
    checkOutput("dead_gaps", bl, 6);

    // Double buffering on channel 2
    dead = 4'd0;
    writeDuty(2, 5);
    repeat (45) applyStimulus();
    waitCnt(0);
    hc = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5)  begin wr = 1'b1; wrCh = 2'd2; wrData = 8'd15; end
      if (i == 19) begin wr = 1'b1; wrCh = 2'd2; wrData = 8'd2;  end
      applyStimulus();
      hc += int'(hi[2]);
    end
    checkOutput("dbuf_current", hc, 5);
    measure(20, 2, hc, lc, bl, sc);
    checkOutput("dbuf_next", hc, 15);
    measure(20, 2, hc, lc, bl, sc);
    checkOutput("dbuf_after", hc, 2);

    // Boundaries: zero duty, duty beyond PERIOD, out-of-range channel write
    period = 8'd99; dead = 4'd2;
    writeDuty(0, 0);
    writeDuty(1, 200);
    repeat (210) applyStimulus();
    measure(100, 0, hc, lc, bl, sc);
    checkOutput("zero_hi", hc, 0);
    checkOutput("zero_full", 32'(full[0]), 32'd0);
    measure(100, 1, hc, lc, bl, sc);
    checkOutput("full_hi", hc, 100);
    checkOutput("full_lo", lc, 0);
    checkOutput("full_flag", 32'(full[1]), 32'd1);
    writeDuty(3, 50);
    repeat (210) applyStimulus();
    measure(100, 0, hc, lc, bl, sc);
    checkOutput("badch_ch0", hc, 0);
    measure(100, 1, hc, lc, bl, sc);
    checkOutput("badch_ch1", hc, 100);

    // Enable drop and restore
    period = 8'd9; dead = 4'd3;
    writeDuty(0, 4);
    repeat (34) applyStimulus();
    e = 1'b0;
    applyStimulus();
    checkOutput("edrop_out", 32'({hi, lo}), 32'd0);
    repeat (3) applyStimulus();
    e = 1'b1;
    first = -1;
    for (int k = 0; k < 16; k++) begin
      applyStimulus();
      if (k == 0) checkOutput("erise_sync", 32'(sync), 32'd1);
      if (hi[0] && first < 0) first = k;
    end
    checkOutput("erise_first_hi", first, 3);

    // Reset pulse mid-period
    repeat (3) applyStimulus();
    rstN = 1'b0;
    applyStimulus();
    checkOutput("rst_mid_out", 32'({hi, lo, sync, full}), 32'd0);
    rstN = 1'b1;
    first = -1;
    for (int k = 1; k < 16; k++) begin
      applyStimulus();
      if (k == 1) checkOutput("rst_sync", 32'(sync), 32'd1);
      if (lo[0] && first < 0) first = k;
    end
    checkOutput("rst_first_lo", first, 3);

    // Random stress
    for (int n = 0; n < 20000; n++) begin
      if ($urandom_range(0, 199) == 0) period = WIDTH'($urandom_range(0, 30));
      if ($urandom_range(0, 299) == 0) dead = DT_WIDTH'($urandom_range(0, 7));
      wr = ($urandom_range(0, 9) == 0);
      wrCh = CH_W'($urandom_range(0, 3));
      wrData = WIDTH'($urandom_range(0, 40));
      if ($urandom_range(0, 499) == 0) e = !e;
      rstN = ($urandom_range(0, 1999) != 0);
      applyStimulus();
    end
    rstN = 1'b1;
    applyStimulus();
    @(negedge CLK);
    #1;
    checkOutput("hi_total", actHiTotal, expHiTotal);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
